// File: rtl/lbuf_port_arbiter_if.sv
// rtl/lbuf_port_arbiter_if.sv - request, response and BRAM signals of the loop-buffer port arbiter
interface lbuf_port_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              flush;
    logic              fill_valid;
    logic              fill_ready;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_data;
    logic              rep_valid;
    logic              rep_ready;
    logic [ADDR_W-1:0] rep_addr;
    logic              rep_rvalid;
    logic [DATA_W-1:0] rep_rdata;
    logic              rep_miss;
    logic              bram_en;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_wdata;
    logic [DATA_W-1:0] bram_rdata;
    logic [ADDR_W:0]   occupancy;
    logic              fill_prio;

    modport slave (
        input  flush, fill_valid, fill_addr, fill_data, rep_valid, rep_addr, bram_rdata,
        output fill_ready, rep_ready, rep_rvalid, rep_rdata, rep_miss,
        output bram_en, bram_we, bram_addr, bram_wdata, occupancy, fill_prio
    );

    modport master (
        output flush, fill_valid, fill_addr, fill_data, rep_valid, rep_addr, bram_rdata,
        input  fill_ready, rep_ready, rep_rvalid, rep_rdata, rep_miss,
        input  bram_en, bram_we, bram_addr, bram_wdata, occupancy, fill_prio
    );
endinterface

// File: rtl/lbuf_port_arbiter.sv
// rtl/lbuf_port_arbiter.sv - single-port loop-buffer BRAM arbiter between fill writes and replay reads
module lbuf_port_arbiter #(
    parameter int ADDR_W       = 6,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    lbuf_port_arbiter_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] STARVE_LAST = 4'(STARVE_LIMIT - 1);

    typedef enum logic [0:0] {NORMAL, FILL_PRIO} state_t;

    state_t            state_q, state_d;
    logic [3:0]        starve_q, starve_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [ADDR_W:0]   occ_q, occ_d;
    logic              rsp_q, rsp_d;
    logic              hit_q, hit_d;
    logic              fill_gnt, rep_gnt;
    logic              rvalid;

    // Grants are suppressed while reset is held so every output is 0 immediately.
    always_comb begin
        fill_gnt = 1'b0;
        rep_gnt  = 1'b0;
        if (reset && !bus.flush) begin
            if (state_q == NORMAL) begin
                rep_gnt  = bus.rep_valid;
                fill_gnt = bus.fill_valid & ~bus.rep_valid;
            end else begin
                fill_gnt = bus.fill_valid;
                rep_gnt  = bus.rep_valid & ~bus.fill_valid;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        valid_d  = valid_q;
        occ_d    = occ_q;
        rsp_d    = rep_gnt;
        hit_d    = valid_q[bus.rep_addr];
        if (bus.flush) begin
            state_d  = NORMAL;
            starve_d = 4'd0;
            valid_d  = '0;
            occ_d    = '0;
        end else begin
            if (fill_gnt) begin
                valid_d[bus.fill_addr] = 1'b1;
                if (!valid_q[bus.fill_addr]) begin
                    occ_d = occ_q + 1'b1;
                end
            end
            if (fill_gnt || !bus.fill_valid) begin
                state_d  = NORMAL;
                starve_d = 4'd0;
            end else if (state_q == NORMAL && starve_q == STARVE_LAST) begin
                state_d  = FILL_PRIO;
                starve_d = 4'd0;
            end else if (starve_q != 4'hF) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= NORMAL;
            starve_q <= 4'd0;
            valid_q  <= '0;
            occ_q    <= '0;
            rsp_q    <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            valid_q  <= valid_d;
            occ_q    <= occ_d;
            rsp_q    <= rsp_d;
            hit_q    <= hit_d;
        end
    end

    // A flush in the response cycle cancels the read granted just before it.
    assign rvalid         = rsp_q & ~bus.flush;
    assign bus.rep_rvalid = rvalid;
    assign bus.rep_miss   = rvalid & ~hit_q;
    assign bus.rep_rdata  = (rvalid && hit_q) ? bus.bram_rdata : '0;

    assign bus.fill_ready = fill_gnt;
    assign bus.rep_ready  = rep_gnt;
    assign bus.bram_en    = fill_gnt | rep_gnt;
    assign bus.bram_we    = fill_gnt;
    assign bus.bram_addr  = fill_gnt ? bus.fill_addr : (rep_gnt ? bus.rep_addr : '0);
    assign bus.bram_wdata = fill_gnt ? bus.fill_data : '0;
    assign bus.occupancy  = occ_q;
    assign bus.fill_prio  = (state_q == FILL_PRIO);
endmodule

// File: tb/tb_lbuf_port_arbiter.sv
// tb/tb_lbuf_port_arbiter.sv - directed self-checking bench for lbuf_port_arbiter
module tb_lbuf_port_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;

    lbuf_port_arbiter_if #(.ADDR_W(6), .DATA_W(32)) bus ();

    lbuf_port_arbiter #(.ADDR_W(6), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Registered-read BRAM; never-written entries read back as 0xDEADBEEF.
    logic [31:0] mem [64];
    logic [63:0] written = '0;
    logic [31:0] bram_q  = '0;
    always @(posedge clk) begin
        if (bus.bram_en) begin
            if (bus.bram_we) begin
                mem[bus.bram_addr]     <= bus.bram_wdata;
                written[bus.bram_addr] <= 1'b1;
            end else begin
                bram_q <= written[bus.bram_addr] ? mem[bus.bram_addr] : 32'hDEADBEEF;
            end
        end
    end
    assign bus.bram_rdata = bram_q;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic fv, input logic [5:0] fa, input logic [31:0] fd,
                         input logic rv, input logic [5:0] ra, input logic fl);
        bus.fill_valid = fv;
        bus.fill_addr  = fa;
        bus.fill_data  = fd;
        bus.rep_valid  = rv;
        bus.rep_addr   = ra;
        bus.flush      = fl;
    endtask

    task automatic idle();
        drive(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b1, 6'd3, 32'h1234, 1'b1, 6'd3, 1'b0);
        tick();
        #1;
        check_eq("rst_fill_ready", bus.fill_ready, 0);
        check_eq("rst_rep_ready",  bus.rep_ready, 0);
        check_eq("rst_bram_en",    bus.bram_en, 0);
        check_eq("rst_bram_addr",  bus.bram_addr, 0);
        check_eq("rst_occupancy",  bus.occupancy, 0);
        check_eq("rst_fill_prio",  bus.fill_prio, 0);
        check_eq("rst_rep_rvalid", bus.rep_rvalid, 0);
        tick();
        idle();
        reset = 1'b1;
        tick();

        // fill addr 3, idle, replay addr 3
        drive(1'b1, 6'd3, 32'h00A00093, 1'b0, 6'd0, 1'b0);
        #1;
        check_eq("t1_fill_ready", bus.fill_ready, 1);
        check_eq("t1_bram_we",    bus.bram_we, 1);
        check_eq("t1_bram_addr",  bus.bram_addr, 3);
        check_eq("t1_bram_wdata", bus.bram_wdata, 32'h00A00093);
        tick();
        idle();
        #1;
        check_eq("t1_idle_we",   bus.bram_we, 0);
        check_eq("t1_occupancy", bus.occupancy, 1);
        tick();
        drive(1'b0, 6'd0, 32'd0, 1'b1, 6'd3, 1'b0);
        #1;
        check_eq("t1_rep_ready", bus.rep_ready, 1);
        check_eq("t1_rd_en",     bus.bram_en, 1);
        check_eq("t1_rd_we",     bus.bram_we, 0);
        check_eq("t1_rd_addr",   bus.bram_addr, 3);
        tick();
        idle();
        #1;
        check_eq("t1_rvalid", bus.rep_rvalid, 1);
        check_eq("t1_rdata",  bus.rep_rdata, 32'h00A00093);
        check_eq("t1_miss",   bus.rep_miss, 0);
        tick();
        check_eq("t1_rvalid_after", bus.rep_rvalid, 0);

        // replay of a never-filled entry
        drive(1'b0, 6'd0, 32'd0, 1'b1, 6'd5, 1'b0);
        tick();
        idle();
        #1;
        check_eq("t2_rvalid",    bus.rep_rvalid, 1);
        check_eq("t2_miss",      bus.rep_miss, 1);
        check_eq("t2_rdata",     bus.rep_rdata, 0);
        check_eq("t2_occupancy", bus.occupancy, 1);
        tick();

        // both requesters held: four replays, then one forced fill
        drive(1'b1, 6'd10, 32'h00000111, 1'b1, 6'd3, 1'b0);
        for (int i = 0; i < 10; i++) begin
            #1;
            check_eq($sformatf("t3_fill_ready_%0d", i), bus.fill_ready, (i % 5 == 4));
            check_eq($sformatf("t3_rep_ready_%0d", i),  bus.rep_ready,  (i % 5 != 4));
            check_eq($sformatf("t3_fill_prio_%0d", i),  bus.fill_prio,  (i % 5 == 4));
            check_eq($sformatf("t3_rvalid_%0d", i),     bus.rep_rvalid, (i > 0 && ((i - 1) % 5 != 4)));
            tick();
        end
        idle();
        #1;
        check_eq("t3_occupancy", bus.occupancy, 2);
        tick();

        // rewrite leaves occupancy unchanged; latest data wins
        drive(1'b1, 6'd7, 32'h70000001, 1'b0, 6'd0, 1'b0);
        tick();
        #1;
        check_eq("t4_occ_a", bus.occupancy, 3);
        drive(1'b1, 6'd7, 32'h70000002, 1'b0, 6'd0, 1'b0);
        tick();
        #1;
        check_eq("t4_occ_b", bus.occupancy, 3);
        drive(1'b1, 6'd8, 32'h80000000, 1'b0, 6'd0, 1'b0);
        tick();
        #1;
        check_eq("t4_occ_c", bus.occupancy, 4);
        drive(1'b0, 6'd0, 32'd0, 1'b1, 6'd7, 1'b0);
        tick();
        idle();
        #1;
        check_eq("t4_rdata", bus.rep_rdata, 32'h70000002);
        check_eq("t4_miss",  bus.rep_miss, 0);
        drive(1'b1, 6'd9, 32'h00000099, 1'b0, 6'd0, 1'b0);
        tick();
        drive(1'b0, 6'd0, 32'd0, 1'b1, 6'd9, 1'b0);
        tick();
        idle();
        #1;
        check_eq("t4_wr_rd_rvalid", bus.rep_rvalid, 1);
        check_eq("t4_wr_rd_rdata",  bus.rep_rdata, 32'h00000099);
        check_eq("t4_wr_rd_miss",   bus.rep_miss, 0);
        check_eq("t4_occ_d",        bus.occupancy, 5);
        tick();

        // flush right after a replay grant
        drive(1'b0, 6'd0, 32'd0, 1'b1, 6'd3, 1'b0);
        tick();
        drive(1'b1, 6'd4, 32'h5, 1'b1, 6'd3, 1'b1);
        #1;
        check_eq("t5_cancel_rvalid", bus.rep_rvalid, 0);
        check_eq("t5_flush_fill",    bus.fill_ready, 0);
        check_eq("t5_flush_rep",     bus.rep_ready, 0);
        check_eq("t5_flush_en",      bus.bram_en, 0);
        tick();
        idle();
        #1;
        check_eq("t5_occupancy", bus.occupancy, 0);
        check_eq("t5_rvalid",    bus.rep_rvalid, 0);
        drive(1'b0, 6'd0, 32'd0, 1'b1, 6'd3, 1'b0);
        tick();
        idle();
        #1;
        check_eq("t5_post_rvalid", bus.rep_rvalid, 1);
        check_eq("t5_post_miss",   bus.rep_miss, 1);
        check_eq("t5_post_rdata",  bus.rep_rdata, 0);
        tick();

        // reset in the middle of a replay stream while in FILL_PRIO
        drive(1'b1, 6'd2, 32'h00000022, 1'b0, 6'd0, 1'b0);
        tick();
        drive(1'b1, 6'd11, 32'h00000033, 1'b1, 6'd2, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        #1;
        check_eq("t6_pre_prio",   bus.fill_prio, 1);
        check_eq("t6_pre_rvalid", bus.rep_rvalid, 1);
        check_eq("t6_pre_rdata",  bus.rep_rdata, 32'h00000022);
        reset = 1'b0;
        #1;
        check_eq("t6_rst_rvalid", bus.rep_rvalid, 0);
        check_eq("t6_rst_rdata",  bus.rep_rdata, 0);
        check_eq("t6_rst_fill",   bus.fill_ready, 0);
        check_eq("t6_rst_rep",    bus.rep_ready, 0);
        check_eq("t6_rst_en",     bus.bram_en, 0);
        check_eq("t6_rst_wdata",  bus.bram_wdata, 0);
        check_eq("t6_rst_occ",    bus.occupancy, 0);
        check_eq("t6_rst_prio",   bus.fill_prio, 0);
        tick();
        tick();
        idle();
        reset = 1'b1;
        #1;
        check_eq("t6_rel_rvalid", bus.rep_rvalid, 0);
        check_eq("t6_rel_prio",   bus.fill_prio, 0);
        tick();
        check_eq("t6_rel_rvalid2", bus.rep_rvalid, 0);
        check_eq("t6_rel_occ",     bus.occupancy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
